// File: rtl/priority_encoder_16_4_pkg.sv
// Shared widths, FSM state type and one-hot helper for the 16-to-4 grant encoder.
package priority_encoder_16_4_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/priority_encoder_16_4_pick_first_16.sv
// Combinational search for the first set bit of a 16-bit vector, scanning upward from a
// start position and wrapping 15 -> 0.
module pick_first_16
    import priority_encoder_16_4_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // 4-bit addition gives the wrap for free
            pos = start + IDX_W'(i);
            if (!found && vec[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_16_4.sv
// Registered 16-to-4 priority encoder with sticky pending capture and grant/ack handshake.
// Define ROUND_ROBIN_EN for rotating priority; otherwise bit 0 always has highest priority.
module priority_encoder_16_4
    import priority_encoder_16_4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [N_REQ-1:0] pending,
    output logic             busy
);

    state_e           state;
    state_e           state_next;
    logic [N_REQ-1:0] pending_next;
    logic [N_REQ-1:0] clr;
    logic [IDX_W-1:0] index_next;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] pick_index;
    logic             pick_found;
    logic             ack_taken;

    assign out_valid = (state == GRANT);
    assign ack_taken = ack && out_valid;
    assign clr       = ack_taken ? idx_to_onehot(out_index) : '0;
    // A new request on the bit being cleared keeps it pending
    assign pending_next = (pending & ~clr) | req;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (ack_taken) begin
            ptr <= out_index + 4'd1;
        end
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    pick_first_16 u_pick (
        .vec   (pending),
        .start (start),
        .found (pick_found),
        .index (pick_index)
    );

    always_comb begin
        state_next = state;
        index_next = out_index;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    index_next = pick_index;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_index <= '0;
            pending   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            out_index <= index_next;
            pending   <= pending_next;
            busy      <= |pending_next;
        end
    end

endmodule

// File: tb/tb_priority_encoder_16_4.sv
// Self-checking bench for priority_encoder_16_4: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_priority_encoder_16_4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        ack;
    logic        out_valid;
    logic [3:0]  out_index;
    logic [15:0] pending;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit m_pend[16];
    bit m_valid;
    int m_idx;
    int m_ptr;

    always #5 clk = ~clk;

    priority_encoder_16_4 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .out_valid (out_valid),
        .out_index (out_index),
        .pending   (pending),
        .busy      (busy)
    );

    function automatic int model_first();
        for (int k = 0; k < 16; k++) begin
            if (m_pend[(m_ptr + k) % 16]) return (m_ptr + k) % 16;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_pend_vec();
        logic [15:0] v;
        for (int k = 0; k < 16; k++) v[k] = m_pend[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_pend[k] = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        int sel;
        bit taken;
        taken = (ack === 1'b1) && m_valid;
        sel   = model_first();
        for (int k = 0; k < 16; k++) begin
            if (taken && k == m_idx) m_pend[k] = req[k];
            else                     m_pend[k] = m_pend[k] | req[k];
        end
        if (m_valid) begin
            if (taken) begin
                m_valid = 1'b0;
`ifdef ROUND_ROBIN_EN
                m_ptr = (m_idx + 1) % 16;
`endif
            end
        end else if (sel >= 0) begin
            m_valid = 1'b1;
            m_idx   = sel;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = '0;
        ack = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        req = 16'h00F0;
        tick();
        req = '0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd4 || pending !== 16'h00F0) begin
            n_fail++;
            $display("FAIL reset_pre_grant: valid=%b idx=%0d pend=%h, required 1/4/00f0",
                     out_valid, out_index, pending);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (pending !== 16'h0000 || out_valid !== 1'b0 || out_index !== 4'd0 || busy !== 1'b0)
        begin
            n_fail++;
            $display("FAIL reset_async: pend=%h valid=%b idx=%0d busy=%b, required 0000/0/0/0",
                     pending, out_valid, out_index, busy);
        end
        model_reset();
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        req = 16'h0200;
        tick();
        req = '0;
        n_checks++;
        if (pending !== 16'h0200 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_edge1: pend=%h valid=%b busy=%b, required 0200/0/1",
                     pending, out_valid, busy);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd9) begin
            n_fail++;
            $display("FAIL single_grant: valid=%b idx=%0d, required 1/9", out_valid, out_index);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (pending !== 16'h0000 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: pend=%h busy=%b valid=%b, required 0000/0/0",
                     pending, busy, out_valid);
        end
    endtask

    task automatic test_fixed_priority();
        int exp_order[3] = '{0, 4, 15};
        apply_reset();
        req = 16'h8011;
        tick();
        req = '0;
        for (int g = 0; g < 3; g++) begin
            int w = 0;
            while (out_valid !== 1'b1 && w < 10) begin
                tick();
                w++;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 4'(exp_order[g])) begin
                n_fail++;
                $display("FAIL prio_grant%0d: valid=%b idx=%0d, required 1/%0d",
                         g, out_valid, out_index, exp_order[g]);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL prio_gap%0d: valid=%b, required 0", g, out_valid);
            end
            if (g < 2) begin
                tick();
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL prio_regrant%0d: valid=%b, required 1", g, out_valid);
                end
            end
        end
        n_checks++;
        if (pending !== 16'h0000) begin
            n_fail++;
            $display("FAIL prio_drained: pend=%h, required 0000", pending);
        end
    endtask

    task automatic test_set_wins();
        apply_reset();
        req = 16'h0008;
        tick();
        req = '0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd3) begin
            n_fail++;
            $display("FAIL setwins_grant: valid=%b idx=%0d, required 1/3", out_valid, out_index);
        end
        ack = 1'b1;
        req = 16'h0008;
        tick();
        ack = 1'b0;
        req = '0;
        n_checks++;
        if (out_valid !== 1'b0 || pending[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL setwins_keep: valid=%b pend3=%b, required 0/1", out_valid, pending[3]);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd3) begin
            n_fail++;
            $display("FAIL setwins_regrant: valid=%b idx=%0d, required 1/3",
                     out_valid, out_index);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (pending !== 16'h0000) begin
            n_fail++;
            $display("FAIL setwins_clear: pend=%h, required 0000", pending);
        end
    endtask

    task automatic test_stray_ack_hold();
        apply_reset();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (pending !== 16'h0000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_idle: pend=%h valid=%b, required 0000/0", pending, out_valid);
        end
        req = 16'h0010;
        tick();
        req = '0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd4 || pending !== 16'h0010) begin
            n_fail++;
            $display("FAIL stray_noclear: valid=%b idx=%0d pend=%h, required 1/4/0010",
                     out_valid, out_index, pending);
        end
        for (int i = 0; i < 10; i++) begin
            req = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 4'd4) begin
                n_fail++;
                $display("FAIL hold_%0d: valid=%b idx=%0d, required 1/4", i, out_valid, out_index);
            end
        end
        req = '0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++;
        if (pending !== 16'h0001) begin
            n_fail++;
            $display("FAIL hold_release: pend=%h, required 0001", pending);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd0) begin
            n_fail++;
            $display("FAIL hold_next: valid=%b idx=%0d, required 1/0", out_valid, out_index);
        end
    endtask

    task automatic test_rotation();
        apply_reset();
        req = 16'h0003;
        for (int g = 0; g < 4; g++) begin
            int w = 0;
            int exp_idx;
`ifdef ROUND_ROBIN_EN
            exp_idx = g % 2;
`else
            exp_idx = 0;
`endif
            while (out_valid !== 1'b1 && w < 10) begin
                tick();
                w++;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 4'(exp_idx)) begin
                n_fail++;
                $display("FAIL rotate_%0d: valid=%b idx=%0d, required 1/%0d",
                         g, out_valid, out_index, exp_idx);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        req = '0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset();
            end
            req = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0000;
            ack = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (out_valid !== m_valid || out_index !== 4'(m_idx) ||
                pending !== model_pend_vec() || busy !== (|model_pend_vec())) begin
                n_fail++;
                $display("FAIL random_%0d: valid=%b idx=%0d pend=%h busy=%b, required %b/%0d/%h/%b",
                         c, out_valid, out_index, pending, busy,
                         m_valid, m_idx, model_pend_vec(), |model_pend_vec());
            end
        end
        req = '0;
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        model_reset();
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fixed_priority();
        test_set_wins();
        test_stray_ack_hold();
        test_rotation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
